// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a shared, registered 8-bit AND/OR/XOR/NOR unit.
// Define ROUND_ROBIN_EN to alternate ties between requesters; otherwise requester 0 wins ties.
module logic_unit_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   op1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [W-1:0] y,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } opcode_t;

  state_t       r_state, w_state_nxt;
  logic         r_win,   w_win_nxt;
  logic [W-1:0] r_a,     w_a_nxt;
  logic [W-1:0] r_b,     w_b_nxt;
  logic [1:0]   r_op,    w_op_nxt;
  logic [1:0]   r_gnt,   w_gnt_nxt;
  logic [1:0]   r_done,  w_done_nxt;
  logic [W-1:0] r_y,     w_y_nxt;
  logic         w_pick;

  function automatic logic [W-1:0] logic_op(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [1:0]   op);
    logic [W-1:0] res;
    case (opcode_t'(op))
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = ~(a | b);
    endcase
    return res;
  endfunction

`ifdef ROUND_ROBIN_EN
  // r_last holds the index of the previous winner; reset to 1 so requester 0 wins the first tie.
  logic r_last, w_last_nxt;

  always_comb begin
    w_pick = (req == 2'b11) ? ~r_last : ~req[0];
  end

  always_comb begin
    w_last_nxt = r_last;
    if (r_state == S_IDLE && |req) w_last_nxt = w_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) r_last <= 1'b1;
    else     r_last <= w_last_nxt;
  end
`else
  always_comb begin
    w_pick = ~req[0];
  end
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_y_nxt     = r_y;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_win_nxt   = w_pick;
          w_a_nxt     = w_pick ? a1  : a0;
          w_b_nxt     = w_pick ? b1  : b0;
          w_op_nxt    = w_pick ? op1 : op0;
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_y_nxt     = logic_op(r_a, r_b, r_op);
        w_done_nxt  = r_gnt;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!req[r_win]) begin
          w_gnt_nxt   = 2'b00;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 2'b00;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign y    = r_y;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter; inputs change and outputs are sampled on negedge.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic [1:0] gnt, done;
  logic [7:0] y;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic_unit_arbiter #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a0   (a0),
    .b0   (b0),
    .op0  (op0),
    .a1   (a1),
    .b1   (b1),
    .op1  (op1),
    .gnt  (gnt),
    .done (done),
    .y    (y),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction: grant, compute with done pulse, winner drops req, back to IDLE.
  task automatic serve(input string tag, input logic [1:0] rq,
                       input logic [1:0] exp_gnt, input logic [7:0] exp_y);
    req = rq;
    step();
    check({tag, " gnt"},      32'(gnt),  32'(exp_gnt));
    check({tag, " busy"},     32'(busy), 32'd1);
    check({tag, " done_pre"}, 32'(done), 32'd0);
    step();
    check({tag, " done"},     32'(done), 32'(exp_gnt));
    check({tag, " y"},        32'(y),    32'(exp_y));
    check({tag, " gnt_hold"}, 32'(gnt),  32'(exp_gnt));
    req = rq & ~exp_gnt;
    step();
    check({tag, " done_clr"}, 32'(done), 32'd0);
    check({tag, " gnt_clr"},  32'(gnt),  32'd0);
    check({tag, " idle"},     32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b11;
    a0 = 8'h00; b0 = 8'h00; op0 = 2'b00;
    a1 = 8'h00; b1 = 8'h00; op1 = 2'b00;

    for (int i = 0; i < 2; i++) begin
      step();
      check("rst gnt",  32'(gnt),  32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst y",    32'(y),    32'd0);
      check("rst busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    req = 2'b00;
    step();
    check("idle noreq gnt", 32'(gnt), 32'd0);

    a0 = 8'hF0; b0 = 8'h00; op0 = 2'b00;
    serve("r0 and", 2'b01, 2'b01, 8'h00);
    b0 = 8'hFF; op0 = 2'b10;
    serve("r0 xor", 2'b01, 2'b01, 8'h0F);

    a1 = 8'hF0; b1 = 8'hAA; op1 = 2'b01;
    serve("r1 or", 2'b10, 2'b10, 8'hFA);
    op1 = 2'b11;
    serve("r1 nor", 2'b10, 2'b10, 8'h05);

    // Tie: requester 0 gives 3C^0F=33, requester 1 gives F0&AA=A0.
    a0 = 8'h3C; b0 = 8'h0F; op0 = 2'b10;
    a1 = 8'hF0; b1 = 8'hAA; op1 = 2'b00;
`ifdef ROUND_ROBIN_EN
    serve("tie1", 2'b11, 2'b01, 8'h33);
    serve("tie2", 2'b11, 2'b10, 8'hA0);
    serve("tie3", 2'b11, 2'b01, 8'h33);
    serve("tie4", 2'b11, 2'b10, 8'hA0);
`else
    serve("tie1", 2'b11, 2'b01, 8'h33);
    serve("tie2", 2'b11, 2'b01, 8'h33);
    serve("tie3", 2'b11, 2'b01, 8'h33);
`endif
    serve("r1 after r0 drop", 2'b10, 2'b10, 8'hA0);

    // Early release plus operand change after grant: AA|55 was latched.
    a0 = 8'hAA; b0 = 8'h55; op0 = 2'b01;
    req = 2'b01;
    step();
    check("early gnt", 32'(gnt), 32'd1);
    a0 = 8'h00; b0 = 8'h00; op0 = 2'b00;
    req = 2'b00;
    step();
    check("early done", 32'(done), 32'd1);
    check("latched y",  32'(y),    32'hFF);
    step();
    check("early done once", 32'(done), 32'd0);
    check("early idle",      32'(busy), 32'd0);
    check("early gnt clr",   32'(gnt),  32'd0);

    // Reset during EXEC: no done, y cleared, then normal service.
    a1 = 8'h0F; b1 = 8'hF0; op1 = 2'b01;
    req = 2'b10;
    step();
    check("mid gnt", 32'(gnt), 32'd2);
    rst = 1'b1;
    step();
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst y",    32'(y),    32'd0);
    check("mid rst gnt",  32'(gnt),  32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    serve("post rst", 2'b10, 2'b10, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
